// File: rtl/ram_mp_arb.sv
// ram_mp_arb -- N-port shared RAM with round-robin arbitration.
//
// NUM_PORTS req/gnt/rvalid masters share one single-port, byte-enabled
// word array. One access is granted per cycle. Every grant is answered one
// cycle later with an rvalid pulse, an error flag and, for reads, the data.
// Addresses at or above MEM_SIZE are answered with err=1 and rdata=0, and
// they never touch the array.
//
// Ports
//   clk_i     clock
//   rst_ni    asynchronous reset, active low
//   en_i      per-port enable; a request is ignored while en_i is 0
//   req_i     per-port access request
//   gnt_o     per-port grant (combinational from en_i/req_i/pointer)
//   rvalid_o  per-port response valid, one cycle after the grant
//   err_o     per-port error flag, qualified by rvalid_o
//   we_i      per-port write enable (1 = write, 0 = read)
//   be_i      per-port byte enables, port p at [p*BE_W +: BE_W]
//   addr_i    per-port byte address, port p at [p*32 +: 32]
//   wdata_i   per-port write data
//   rdata_o   per-port read data, valid with rvalid_o and held afterwards
module ram_mp_arb #(
  parameter int MEM_SIZE   = 4096,
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            en_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [NUM_PORTS-1:0]            err_o,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*32-1:0]         addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o
);

  localparam int BE_W       = DATA_WIDTH / 8;
  localparam int DEPTH      = MEM_SIZE / BE_W;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int OFS        = $clog2(BE_W);
  localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] act;
  logic [NUM_PORTS-1:0] gnt;
  logic [PTR_W-1:0]     win;
  logic                 any_act;

  assign act     = en_i & req_i;
  assign any_act = |act;
  assign gnt_o   = gnt;

  // ---------------------------------------------------------------- arbiter
  generate
    if (NUM_PORTS == 1) begin : g_single
      assign gnt = act;
      assign win = '0;
    end else begin : g_rr
      logic [PTR_W-1:0] rr_reg;

      // Scan from the highest offset down so the port closest to rr_reg
      // (offset 0) is the last assignment and therefore wins.
      always_comb begin
        win = rr_reg;
        gnt = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
          int idx;
          idx = int'(rr_reg) + i;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          if (act[idx]) win = PTR_W'(idx);
        end
        if (any_act) gnt[win] = 1'b1;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rr_reg <= '0;
        end else if (any_act) begin
          rr_reg <= (win == PTR_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
        end
      end
    end
  endgenerate

  // ------------------------------------------------- winner request select
  logic                  sel_we;
  logic [BE_W-1:0]       sel_be;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;

  always_comb begin
    sel_we    = we_i[win];
    sel_be    = be_i[int'(win)*BE_W +: BE_W];
    sel_addr  = addr_i[int'(win)*32 +: 32];
    sel_wdata = wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  end

  // The full 32-bit compare covers every address bit, so aliasing above
  // MEM_SIZE is always reported as an error rather than wrapping.
  assign in_range = (sel_addr < 32'(MEM_SIZE));
  assign widx     = sel_addr[ADDR_WIDTH+OFS-1:OFS];
  assign wr_en    = any_act & sel_we & in_range;
  assign rd_en    = any_act & ~sel_we & in_range;

  // ------------------------------------------------------------ storage
  // No reset on the array or its read register so it maps onto block RAM.
  // The read samples the old word when a write hits the same address.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (sel_be[k]) mem[widx][k*8 +: 8] <= sel_wdata[k*8 +: 8];
      end
    end
    if (rd_en) mem_q <= mem[widx];
  end

  // ----------------------------------------------------- per-port response
  // mem_q is shared and may be overwritten by the next read, so each port
  // captures its word into hold_reg during its own rvalid cycle.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic                  rvalid_reg;
      logic                  err_reg;
      logic                  rd_ok_reg;
      logic [DATA_WIDTH-1:0] hold_reg;
      logic [DATA_WIDTH-1:0] rdata_cur;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          rd_ok_reg  <= 1'b0;
          hold_reg   <= '0;
        end else begin
          rvalid_reg <= gnt[gi];
          if (gnt[gi]) begin
            err_reg   <= ~in_range;
            rd_ok_reg <= rd_en;
          end
          if (rvalid_reg) hold_reg <= rdata_cur;
        end
      end

      // Good read -> fresh word; error -> zero; in-range write -> hold.
      always_comb begin
        rdata_cur = hold_reg;
        if (rvalid_reg) begin
          if (rd_ok_reg)    rdata_cur = mem_q;
          else if (err_reg) rdata_cur = '0;
        end
      end

      assign rvalid_o[gi]                          = rvalid_reg;
      assign err_o[gi]                             = err_reg;
      assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH]  = rdata_cur;
    end
  endgenerate

endmodule

// File: tb/tb_ram_mp_arb.sv
module tb_ram_mp_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Two-port instance
  logic [1:0]  en2 = '0, req2 = '0, we2 = '0;
  logic [7:0]  be2 = '0;
  logic [63:0] addr2 = '0, wdata2 = '0;
  logic [1:0]  gnt2, rvalid2, err2;
  logic [63:0] rdata2;

  // Four-port instance
  logic [3:0]   en4 = '0, req4 = '0, we4 = '0;
  logic [15:0]  be4 = '0;
  logic [127:0] addr4 = '0, wdata4 = '0;
  logic [3:0]   gnt4, rvalid4, err4;
  logic [127:0] rdata4;

  ram_mp_arb #(.MEM_SIZE(4096), .NUM_PORTS(2), .DATA_WIDTH(32)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .req_i(req2), .gnt_o(gnt2),
    .rvalid_o(rvalid2), .err_o(err2), .we_i(we2), .be_i(be2),
    .addr_i(addr2), .wdata_i(wdata2), .rdata_o(rdata2)
  );

  ram_mp_arb #(.MEM_SIZE(4096), .NUM_PORTS(4), .DATA_WIDTH(32)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en4), .req_i(req4), .gnt_o(gnt4),
    .rvalid_o(rvalid4), .err_o(err4), .we_i(we4), .be_i(be4),
    .addr_i(addr4), .wdata_i(wdata4), .rdata_o(rdata4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard
  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] mdl [1024];
  logic [31:0] hold_m [2];
  int          rr_m = 0;
  int          rv_cnt [2];

  task automatic model_reset();
    rr_m = 0;
    hold_m[0] = '0;
    hold_m[1] = '0;
    sb.delete();
  endtask

  // Caller is at a negedge; returns at the next negedge.
  task automatic cycle2(input logic [1:0] en, input logic [1:0] req, input logic [1:0] we,
                        input logic [3:0] b0, input logic [3:0] b1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    logic [1:0]  act;
    logic [1:0]  exp_gnt;
    int          win;
    bit          found;
    logic [31:0] a, d, r;
    logic [3:0]  b;
    logic        oor;
    resp_t       e;
    en2 = en; req2 = req; we2 = we;
    be2 = {b1, b0}; addr2 = {a1, a0}; wdata2 = {d1, d0};
    #1;
    act = en & req;
    found = 1'b0;
    win = 0;
    for (int i = 0; i < 2; i++) begin
      int idx;
      idx = (rr_m + i) % 2;
      if (!found && act[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    exp_gnt = found ? (2'b01 << win) : 2'b00;
    check_val("gnt2", 64'(gnt2), 64'(exp_gnt));
    if (found) begin
      a = (win == 1) ? a1 : a0;
      d = (win == 1) ? d1 : d0;
      b = (win == 1) ? b1 : b0;
      oor = (a >= 32'd4096);
      if (we[win]) begin
        if (!oor) begin
          for (int k = 0; k < 4; k++)
            if (b[k]) mdl[a[11:2]][k*8 +: 8] = d[k*8 +: 8];
        end
        r = oor ? 32'h0 : hold_m[win];
      end else begin
        r = oor ? 32'h0 : mdl[a[11:2]];
      end
      hold_m[win] = r;
      sb.push_back('{win, r, oor});
      rr_m = (win + 1) % 2;
      $display("txn: port %0d %s addr 0x%0h data 0x%0h be %b -> expect rdata 0x%0h err %0d",
               win, we[win] ? "WR" : "RD", a, d, b, r, oor);
    end
    @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val("rvalid2", 64'(rvalid2), 64'(2'b01 << e.port));
      check_val("rdata2", 64'(rdata2[e.port*32 +: 32]), 64'(e.rdata));
      check_val("err2", 64'(err2[e.port]), 64'(e.err));
      if (rvalid2[e.port]) rv_cnt[e.port]++;
    end else begin
      check_val("rvalid2_idle", 64'(rvalid2), 64'h0);
    end
    en2 = '0; req2 = '0; we2 = '0;
  endtask

  task automatic p0_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    cycle2(2'b01, 2'b01, 2'b01, b, 4'h0, a, 32'h0, d, 32'h0);
  endtask
  task automatic p0_rd(input logic [31:0] a);
    cycle2(2'b01, 2'b01, 2'b00, 4'hF, 4'h0, a, 32'h0, 32'h0, 32'h0);
  endtask
  task automatic p1_wr(input logic [31:0] a, input logic [31:0] d);
    cycle2(2'b10, 2'b10, 2'b10, 4'h0, 4'hF, 32'h0, a, 32'h0, d);
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    rv_cnt[0] = 0;
    rv_cnt[1] = 0;
    repeat (3) @(negedge clk);
    check_val("rst_rvalid2", 64'(rvalid2), 64'h0);
    check_val("rst_err2", 64'(err2), 64'h0);
    check_val("rst_rdata2", rdata2, 64'h0);
    check_val("rst_gnt2", 64'(gnt2), 64'h0);
    check_val("rst_rvalid4", 64'(rvalid4), 64'h0);
    rst_n = 1'b1;

    // Single-port write then read-back
    p0_wr(32'h10, 32'hDEADBEEF, 4'hF);
    p0_rd(32'h10);
    check_val("readback", 64'(rdata2[31:0]), 64'hDEADBEEF);

    // Byte enables
    p0_wr(32'h20, 32'h11223344, 4'hF);
    p0_wr(32'h20, 32'hAABBCCDD, 4'b0101);
    p0_rd(32'h20);
    check_val("byte_en", 64'(rdata2[31:0]), 64'h11BB33DD);

    // Idle cycle, then a word at 0x0 via P1
    cycle2(2'b00, 2'b11, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    p1_wr(32'h0, 32'hCAFEF00D);

    // Contention from reset: both read continuously for 6 cycles
    pulse_reset();
    rv_cnt[0] = 0;
    rv_cnt[1] = 0;
    for (int c = 0; c < 6; c++)
      cycle2(2'b11, 2'b11, 2'b00, 4'hF, 4'hF, 32'h10, 32'h20, 32'h0, 32'h0);
    check_val("rv_cnt_p0", 64'(rv_cnt[0]), 64'd3);
    check_val("rv_cnt_p1", 64'(rv_cnt[1]), 64'd3);

    // Out of range
    p0_rd(32'h1000);
    check_val("oor_err", 64'(err2[0]), 64'h1);
    p0_wr(32'h1000, 32'h55555555, 4'hF);
    p0_rd(32'h0);
    check_val("oor_untouched", 64'(rdata2[31:0]), 64'hCAFEF00D);

    // Reset in the cycle after a grant drops the response
    en2 = 2'b01; req2 = 2'b01; we2 = 2'b00; addr2 = {32'h0, 32'h10};
    #1;
    check_val("pre_rst_gnt", 64'(gnt2), 64'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en2 = '0; req2 = '0;
    @(negedge clk);
    check_val("midrst_rvalid", 64'(rvalid2), 64'h0);
    check_val("midrst_rdata", rdata2, 64'h0);
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_rvalid_late", 64'(rvalid2), 64'h0);
    rst_n = 1'b1;
    model_reset();
    cycle2(2'b11, 2'b11, 2'b00, 4'hF, 4'hF, 32'h10, 32'h20, 32'h0, 32'h0);
    check_val("post_rst_p0_first", 64'(rdata2[31:0]), 64'hDEADBEEF);

    // Four ports, only P1 and P3 active (pointer is 0 after the reset)
    begin
      int          rr4;
      logic [3:0]  exp4, prev4;
      rr4 = 0;
      prev4 = '0;
      en4 = 4'b1010; req4 = 4'b1010; we4 = '0; addr4 = {4{32'h40}};
      for (int c = 0; c < 6; c++) begin
        bit found;
        #1;
        found = 1'b0;
        exp4 = '0;
        for (int i = 0; i < 4; i++) begin
          int idx;
          idx = (rr4 + i) % 4;
          if (!found && en4[idx] && req4[idx]) begin
            exp4 = 4'b0001 << idx;
            rr4 = (idx + 1) % 4;
            found = 1'b1;
          end
        end
        check_val("gnt4", 64'(gnt4), 64'(exp4));
        $display("txn4: cycle %0d expected grant %b", c, exp4);
        prev4 = exp4;
        @(posedge clk);
        @(negedge clk);
        check_val("rvalid4", 64'(rvalid4), 64'(prev4));
        check_val("err4", 64'(err4), 64'h0);
      end
      en4 = '0; req4 = '0;
      @(negedge clk);
      check_val("rvalid4_idle", 64'(rvalid4), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
